search_time_manager: RTL and testbench

Sequences each search of `engine_coordinator`: on a UCI `go` it computes a per-move time budget, converts it to clock cycles and waits for the engine to be ready. It then launches the search and drives the engine's `time_in` countdown, forcing a stop on expiry or on UCI `stop`. It sits between `uci_handler` and `engine_coordinator` in `top_level`, on the `clk_game` domain, and replaces the ad-hoc `coord_time` countdown logic.

---
 rtl/search_time_manager.sv | 238 +++++++++++++++++++++++
 tb/tb_search_time_manager.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/search_time_manager.sv
// -----------------------------------------------------------------------------
// search_time_manager
//
// Sequences one engine search per UCI "go". It computes a per-move time budget
// in milliseconds, converts it to clock cycles with a 32-step shift-add
// multiply, and waits for the engine to be ready. It then launches the search
// and drives a cycle countdown into the engine. A stop is forced when the
// countdown expires or when UCI "stop" arrives.
//
// Ports
//   clk_in          : system clock (clk_game)
//   rst_in          : synchronous, active-high reset
//   go_in           : one-cycle pulse, start a search (honoured only when idle)
//   time_ms_in      : side-to-move remaining time, ms
//   inc_ms_in       : side-to-move increment, ms
//   movetime_ms_in  : fixed move time, ms (0 = unused)
//   infinite_in     : "go infinite", no budget applies
//   stop_in         : one-cycle pulse, UCI "stop"
//   engine_ready_in : engine is ready to accept a go
//   engine_done_in  : engine has produced its bestmove
//   search_go_out   : one-cycle pulse launching the engine search
//   time_out        : cycles remaining for the engine
//   stop_out        : high while a forced stop is pending
//   busy_out        : high whenever not idle
//   budget_ms_out   : budget latched for the current search, ms
// -----------------------------------------------------------------------------
module search_time_manager #(
  parameter int unsigned CLOCK_FREQ = 50_000_000,
  parameter int unsigned SAFETY_MS  = 50
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        go_in,
  input  logic [31:0] time_ms_in,
  input  logic [31:0] inc_ms_in,
  input  logic [31:0] movetime_ms_in,
  input  logic        infinite_in,
  input  logic        stop_in,
  input  logic        engine_ready_in,
  input  logic        engine_done_in,
  output logic        search_go_out,
  output logic [31:0] time_out,
  output logic        stop_out,
  output logic        busy_out,
  output logic [31:0] budget_ms_out
);

  localparam int unsigned CYC_PER_MS = CLOCK_FREQ / 1000;
  localparam logic [32:0] LP_SAFETY  = 33'(SAFETY_MS);
  localparam logic [63:0] LP_CYC     = 64'(CYC_PER_MS);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_CALC       = 3'd1,
    S_WAIT_READY = 3'd2,
    S_RUN        = 3'd3,
    S_STOP       = 3'd4
  } state_t;

  state_t      r_state;
  logic        r_infinite;
  logic [63:0] r_acc;
  logic [63:0] r_mcand;
  logic [31:0] r_mplier;
  logic [4:0]  r_cnt;
  logic        r_search_go;
  logic [31:0] r_time;
  logic        r_stop;
  logic        r_busy;
  logic [31:0] r_budget;

  logic [32:0] w_mt;
  logic [32:0] w_mt_sub;
  logic [32:0] w_raw;
  logic [32:0] w_cap;
  logic [32:0] w_min;
  logic [31:0] w_budget;
  logic [63:0] w_acc_next;
  logic [31:0] w_product_sat;

  // Budget in ms from the inputs presented alongside go_in (33-bit intermediates).
  always_comb begin
    w_mt = {1'b0, movetime_ms_in};
    if (w_mt > LP_SAFETY) begin
      w_mt_sub = w_mt - LP_SAFETY;
    end else begin
      w_mt_sub = 33'd0;
    end

    // Remaining/32 plus increment, capped so the safety margin is never spent.
    w_raw = {6'd0, time_ms_in[31:5]} + {1'b0, inc_ms_in};
    if ({1'b0, time_ms_in} > LP_SAFETY) begin
      w_cap = {1'b0, time_ms_in} - LP_SAFETY;
    end else begin
      w_cap = 33'd0;
    end
    if (w_raw < w_cap) begin
      w_min = w_raw;
    end else begin
      w_min = w_cap;
    end

    // Both paths clamp to at least 1 ms; both results fit in 32 bits.
    if (movetime_ms_in != 32'd0) begin
      if (w_mt_sub == 33'd0) begin
        w_budget = 32'd1;
      end else begin
        w_budget = w_mt_sub[31:0];
      end
    end else begin
      if (w_min == 33'd0) begin
        w_budget = 32'd1;
      end else begin
        w_budget = w_min[31:0];
      end
    end
  end

  // One shift-add step of budget x cycles-per-ms, plus saturation of the final product.
  always_comb begin
    if (r_mplier[0]) begin
      w_acc_next = r_acc + r_mcand;
    end else begin
      w_acc_next = r_acc;
    end
    if (|r_acc[63:32]) begin
      w_product_sat = 32'hFFFF_FFFF;
    end else begin
      w_product_sat = r_acc[31:0];
    end
  end

  // Search sequencer: state, multiplier datapath and all registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state     <= S_IDLE;
      r_infinite  <= 1'b0;
      r_acc       <= 64'd0;
      r_mcand     <= 64'd0;
      r_mplier    <= 32'd0;
      r_cnt       <= 5'd0;
      r_search_go <= 1'b0;
      r_time      <= 32'd0;
      r_stop      <= 1'b0;
      r_busy      <= 1'b0;
      r_budget    <= 32'd0;
    end else begin
      r_search_go <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (go_in) begin
            r_infinite <= infinite_in;
            r_budget   <= infinite_in ? 32'd0 : w_budget;
            r_mplier   <= infinite_in ? 32'd0 : w_budget;
            r_acc      <= 64'd0;
            r_mcand    <= LP_CYC;
            r_cnt      <= 5'd0;
            r_busy     <= 1'b1;
            r_state    <= S_CALC;
          end else begin
            r_state <= S_IDLE;
          end
        end

        // Exactly 32 steps regardless of operand value, so latency is fixed.
        S_CALC: begin
          r_acc    <= w_acc_next;
          r_mcand  <= {r_mcand[62:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[31:1]};
          r_cnt    <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_state <= S_WAIT_READY;
          end else begin
            r_state <= S_CALC;
          end
        end

        S_WAIT_READY: begin
          if (stop_in) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (engine_ready_in) begin
            r_search_go <= 1'b1;
            r_time      <= r_infinite ? 32'hFFFF_FFFF : w_product_sat;
            r_state     <= S_RUN;
          end else begin
            r_state <= S_WAIT_READY;
          end
        end

        // Engine completion wins over both expiry and stop in the same cycle.
        S_RUN: begin
          if (engine_done_in) begin
            r_time  <= 32'd0;
            r_stop  <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (stop_in || (!r_infinite && (r_time == 32'd0))) begin
            r_time  <= 32'd0;
            r_stop  <= 1'b1;
            r_state <= S_STOP;
          end else if (!r_infinite) begin
            r_time  <= r_time - 32'd1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_RUN;
          end
        end

        S_STOP: begin
          r_time <= 32'd0;
          if (engine_done_in) begin
            r_stop  <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_stop  <= 1'b1;
            r_state <= S_STOP;
          end
        end

        default: begin
          r_time  <= 32'd0;
          r_stop  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign search_go_out = r_search_go;
  assign time_out      = r_time;
  assign stop_out      = r_stop;
  assign busy_out      = r_busy;
  assign budget_ms_out = r_budget;

endmodule

// File: tb/tb_search_time_manager.sv
// Directed bench for search_time_manager. Two instances share all inputs:
// u_slow (CLOCK_FREQ 10 kHz, 10 cycles/ms) carries most checks, and u_fast
// (50 MHz) covers product saturation. Inputs are driven and outputs sampled
// 1 ns after each rising edge. "Cycle n" means n edges after the edge that
// sampled go_in.
module tb_search_time_manager;

  logic        clk;
  logic        rst;
  logic        go;
  logic [31:0] time_ms;
  logic [31:0] inc_ms;
  logic [31:0] movetime_ms;
  logic        inf;
  logic        stop;
  logic        ready;
  logic        done;

  logic        s_go;
  logic [31:0] s_time;
  logic        s_stop;
  logic        s_busy;
  logic [31:0] s_budget;

  logic        f_go;
  logic [31:0] f_time;
  logic        f_stop;
  logic        f_busy;
  logic [31:0] f_budget;

  int vec;
  int errs;

  search_time_manager #(.CLOCK_FREQ(10_000), .SAFETY_MS(50)) u_slow (
    .clk_in(clk), .rst_in(rst), .go_in(go), .time_ms_in(time_ms),
    .inc_ms_in(inc_ms), .movetime_ms_in(movetime_ms), .infinite_in(inf),
    .stop_in(stop), .engine_ready_in(ready), .engine_done_in(done),
    .search_go_out(s_go), .time_out(s_time), .stop_out(s_stop),
    .busy_out(s_busy), .budget_ms_out(s_budget)
  );

  search_time_manager #(.CLOCK_FREQ(50_000_000), .SAFETY_MS(50)) u_fast (
    .clk_in(clk), .rst_in(rst), .go_in(go), .time_ms_in(time_ms),
    .inc_ms_in(inc_ms), .movetime_ms_in(movetime_ms), .infinite_in(inf),
    .stop_in(stop), .engine_ready_in(ready), .engine_done_in(done),
    .search_go_out(f_go), .time_out(f_time), .stop_out(f_stop),
    .busy_out(f_busy), .budget_ms_out(f_budget)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Pulse go with the current operands; returns at cycle 1.
  task automatic pulse_go;
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic pulse_done;
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick_n(2);
    rst = 1'b0;
    vec++; if (s_go !== 1'b0) begin errs++; $display("FAIL reset_go: got %0b want 0", s_go); end
    vec++; if (s_time !== 32'd0) begin errs++; $display("FAIL reset_time: got %0d want 0", s_time); end
    vec++; if (s_stop !== 1'b0) begin errs++; $display("FAIL reset_stop: got %0b want 0", s_stop); end
    vec++; if (s_busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %0b want 0", s_busy); end
    vec++; if (s_budget !== 32'd0) begin errs++; $display("FAIL reset_budget: got %0d want 0", s_budget); end
    vec++; if (f_busy !== 1'b0) begin errs++; $display("FAIL reset_fast_busy: got %0b want 0", f_busy); end
  endtask

  // time 60000, inc 1000: budget 1875+1000 = 2875 ms, 28750 cycles.
  // time_out = 28750-(n-34) at cycle n, so 0 at 28784 and stop at 28785.
  task automatic test_timed_search(input string tag);
    time_ms = 32'd60000; inc_ms = 32'd1000; movetime_ms = 32'd0; inf = 1'b0; ready = 1'b1;
    pulse_go();
    vec++; if (s_budget !== 32'd2875) begin errs++; $display("FAIL %s_budget: got %0d want 2875", tag, s_budget); end
    vec++; if (s_busy !== 1'b1) begin errs++; $display("FAIL %s_busy: got %0b want 1", tag, s_busy); end
    tick_n(32); // cycle 33
    vec++; if (s_go !== 1'b0) begin errs++; $display("FAIL %s_go_early: got %0b want 0 at cycle 33", tag, s_go); end
    tick(); // cycle 34
    vec++; if (s_go !== 1'b1) begin errs++; $display("FAIL %s_go_34: got %0b want 1", tag, s_go); end
    vec++; if (s_time !== 32'd28750) begin errs++; $display("FAIL %s_time_34: got %0d want 28750", tag, s_time); end
    tick(); // cycle 35
    vec++; if (s_go !== 1'b0) begin errs++; $display("FAIL %s_go_35: got %0b want 0", tag, s_go); end
    vec++; if (s_time !== 32'd28749) begin errs++; $display("FAIL %s_time_35: got %0d want 28749", tag, s_time); end
    tick_n(28784 - 35); // cycle 28784
    vec++; if (s_time !== 32'd0 || s_stop !== 1'b0) begin errs++; $display("FAIL %s_zero: got time %0d stop %0b want 0/0", tag, s_time, s_stop); end
    tick(); // cycle 28785
    vec++; if (s_stop !== 1'b1 || s_busy !== 1'b1) begin errs++; $display("FAIL %s_expire: got stop %0b busy %0b want 1/1", tag, s_stop, s_busy); end
    pulse_done();
    vec++; if (s_busy !== 1'b0 || s_stop !== 1'b0 || s_time !== 32'd0) begin errs++; $display("FAIL %s_done: got busy %0b stop %0b time %0d want 0/0/0", tag, s_busy, s_stop, s_time); end
    vec++; if (s_budget !== 32'd2875) begin errs++; $display("FAIL %s_budget_kept: got %0d want 2875", tag, s_budget); end
  endtask

  // movetime 500 -> 450 ms -> 4500 cycles; stop_in at cycle 34 -> STOP at 35.
  task automatic test_movetime_stop;
    time_ms = 32'd0; inc_ms = 32'd0; movetime_ms = 32'd500; inf = 1'b0; ready = 1'b1;
    pulse_go();
    vec++; if (s_budget !== 32'd450) begin errs++; $display("FAIL mt_budget: got %0d want 450", s_budget); end
    tick_n(33); // cycle 34
    vec++; if (s_time !== 32'd4500) begin errs++; $display("FAIL mt_time: got %0d want 4500", s_time); end
    stop = 1'b1; tick(); stop = 1'b0; // cycle 35
    vec++; if (s_time !== 32'd0 || s_stop !== 1'b1) begin errs++; $display("FAIL mt_stop: got time %0d stop %0b want 0/1", s_time, s_stop); end
    pulse_done();
    vec++; if (s_busy !== 1'b0 || s_stop !== 1'b0) begin errs++; $display("FAIL mt_done: got busy %0b stop %0b want 0/0", s_busy, s_stop); end
  endtask

  // time 40 (< safety) inc 0 -> budget clamps to 1 ms = 10 cycles.
  task automatic test_min_budget;
    time_ms = 32'd40; inc_ms = 32'd0; movetime_ms = 32'd0; inf = 1'b0; ready = 1'b1;
    pulse_go();
    vec++; if (s_budget !== 32'd1) begin errs++; $display("FAIL min_budget: got %0d want 1", s_budget); end
    tick_n(33); // cycle 34
    vec++; if (s_time !== 32'd10) begin errs++; $display("FAIL min_time: got %0d want 10", s_time); end
    tick_n(9); // cycle 43
    vec++; if (s_time !== 32'd1 || s_stop !== 1'b0) begin errs++; $display("FAIL min_one: got time %0d stop %0b want 1/0", s_time, s_stop); end
    tick(); // cycle 44
    vec++; if (s_time !== 32'd0 || s_stop !== 1'b0) begin errs++; $display("FAIL min_zero: got time %0d stop %0b want 0/0", s_time, s_stop); end
    tick(); // cycle 45
    vec++; if (s_stop !== 1'b1) begin errs++; $display("FAIL min_stop: got %0b want 1", s_stop); end
    pulse_done();
    vec++; if (s_busy !== 1'b0) begin errs++; $display("FAIL min_done: got %0b want 0", s_busy); end
  endtask

  // movetime 100050 -> 100000 ms; x50000 = 5e9 saturates, x10 = 1e6 does not.
  task automatic test_saturate;
    time_ms = 32'd0; inc_ms = 32'd0; movetime_ms = 32'd100050; inf = 1'b0; ready = 1'b1;
    pulse_go();
    vec++; if (f_budget !== 32'd100000) begin errs++; $display("FAIL sat_budget: got %0d want 100000", f_budget); end
    tick_n(33);
    vec++; if (f_time !== 32'hFFFF_FFFF) begin errs++; $display("FAIL sat_time: got %h want ffffffff", f_time); end
    vec++; if (s_time !== 32'd1000000) begin errs++; $display("FAIL sat_slow_time: got %0d want 1000000", s_time); end
    pulse_done();
    vec++; if (f_busy !== 1'b0 || s_busy !== 1'b0) begin errs++; $display("FAIL sat_done: got busy %0b/%0b want 0/0", f_busy, s_busy); end
  endtask

  task automatic test_infinite;
    time_ms = 32'd60000; inc_ms = 32'd1000; movetime_ms = 32'd0; inf = 1'b1; ready = 1'b1;
    pulse_go();
    vec++; if (s_budget !== 32'd0) begin errs++; $display("FAIL inf_budget: got %0d want 0", s_budget); end
    tick_n(33); // cycle 34
    vec++; if (s_go !== 1'b1 || s_time !== 32'hFFFF_FFFF) begin errs++; $display("FAIL inf_start: got go %0b time %h want 1/ffffffff", s_go, s_time); end
    tick_n(10000);
    vec++; if (s_time !== 32'hFFFF_FFFF || s_stop !== 1'b0) begin errs++; $display("FAIL inf_hold: got time %h stop %0b want ffffffff/0", s_time, s_stop); end
    stop = 1'b1; tick(); stop = 1'b0;
    vec++; if (s_time !== 32'd0 || s_stop !== 1'b1) begin errs++; $display("FAIL inf_stop: got time %0d stop %0b want 0/1", s_time, s_stop); end
    pulse_done();
    vec++; if (s_busy !== 1'b0 || s_stop !== 1'b0) begin errs++; $display("FAIL inf_done: got busy %0b stop %0b want 0/0", s_busy, s_stop); end
    inf = 1'b0;
  endtask

  // Ready low through cycles 33..52 (20 cycles) delays search_go to cycle 54.
  task automatic test_ready_delay;
    time_ms = 32'd0; inc_ms = 32'd0; movetime_ms = 32'd500; inf = 1'b0; ready = 1'b0;
    pulse_go();
    tick_n(52); // cycle 53
    ready = 1'b1;
    vec++; if (s_go !== 1'b0 || s_busy !== 1'b1) begin errs++; $display("FAIL rdy_wait: got go %0b busy %0b want 0/1", s_go, s_busy); end
    tick(); // cycle 54
    vec++; if (s_go !== 1'b1 || s_time !== 32'd4500) begin errs++; $display("FAIL rdy_go: got go %0b time %0d want 1/4500", s_go, s_time); end
    pulse_done();
    vec++; if (s_busy !== 1'b0) begin errs++; $display("FAIL rdy_done: got %0b want 0", s_busy); end
  endtask

  task automatic test_wait_abort;
    time_ms = 32'd0; inc_ms = 32'd0; movetime_ms = 32'd500; inf = 1'b0; ready = 1'b0;
    pulse_go();
    tick_n(32); // cycle 33, WAIT_READY
    stop = 1'b1; tick(); stop = 1'b0; // cycle 34
    ready = 1'b1;
    vec++; if (s_busy !== 1'b0 || s_go !== 1'b0) begin errs++; $display("FAIL abort_idle: got busy %0b go %0b want 0/0", s_busy, s_go); end
    tick_n(3);
    vec++; if (s_go !== 1'b0 || s_time !== 32'd0) begin errs++; $display("FAIL abort_nogo: got go %0b time %0d want 0/0", s_go, s_time); end
  endtask

  // A go in RUN changes nothing; done+stop together return to IDLE.
  task automatic test_back_to_back;
    time_ms = 32'd0; inc_ms = 32'd0; movetime_ms = 32'd500; inf = 1'b0; ready = 1'b1;
    pulse_go();
    tick_n(39); // cycle 40, time 4500-6 = 4494
    movetime_ms = 32'd1000;
    pulse_go(); // cycle 41
    vec++; if (s_budget !== 32'd450 || s_time !== 32'd4493 || s_busy !== 1'b1) begin errs++; $display("FAIL b2b_ignore: got budget %0d time %0d busy %0b want 450/4493/1", s_budget, s_time, s_busy); end
    stop = 1'b1; done = 1'b1; tick(); stop = 1'b0; done = 1'b0;
    vec++; if (s_busy !== 1'b0 || s_stop !== 1'b0 || s_time !== 32'd0) begin errs++; $display("FAIL b2b_done_stop: got busy %0b stop %0b time %0d want 0/0/0", s_busy, s_stop, s_time); end
  endtask

  task automatic test_reset_mid;
    time_ms = 32'd60000; inc_ms = 32'd1000; movetime_ms = 32'd0; inf = 1'b0; ready = 1'b1;
    pulse_go();
    tick_n(9); // cycle 10, CALC
    rst = 1'b1; tick(); rst = 1'b0;
    vec++; if (s_busy !== 1'b0 || s_budget !== 32'd0 || s_time !== 32'd0) begin errs++; $display("FAIL rst_calc: got busy %0b budget %0d time %0d want 0/0/0", s_busy, s_budget, s_time); end
    pulse_go();
    tick_n(99); // cycle 100, RUN
    rst = 1'b1; tick(); rst = 1'b0;
    vec++; if (s_busy !== 1'b0 || s_budget !== 32'd0 || s_time !== 32'd0 || s_stop !== 1'b0 || s_go !== 1'b0) begin errs++; $display("FAIL rst_run: got busy %0b budget %0d time %0d stop %0b go %0b want all 0", s_busy, s_budget, s_time, s_stop, s_go); end
    test_timed_search("rerun");
  endtask

  initial begin
    vec = 0; errs = 0;
    rst = 1'b1; go = 1'b0; time_ms = 32'd0; inc_ms = 32'd0; movetime_ms = 32'd0;
    inf = 1'b0; stop = 1'b0; ready = 1'b1; done = 1'b0;
    test_reset();
    test_timed_search("first");
    test_movetime_stop();
    test_min_budget();
    test_saturate();
    test_infinite();
    test_ready_delay();
    test_wait_abort();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
